hazard_forward_unit: RTL and testbench
======================================

# hazard_forward_unit

Second-generation hazard controller for the five-stage pipeline. It replaces the combinational EX-stage forwarding selector and adds three things:
- correct forwarding priority, with x0 suppression;
- load-use stall detection;
- a counter-driven stall sequencer for the multi-cycle multiply/divide unit (MDU), plus branch-flush control and saturating stall/flush performance counters.

It sits beside the ID/EX boundary. It drives the PC, IF/ID and ID/EX write enables, the bubble/flush controls and the EX operand multiplexers.

## Interface

Parameters:
- REG_ADDR_W, 5, register-index width.
- MDU_LATENCY, 4, number of EX cycles an MDU instruction occupies (≥1). A value of 1 disables MDU stalling.
- CNT_W, 16, width of the performance counters.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high.
- ifid_rs1, ifid_rs2  input  REG_ADDR_W  source indices of the instruction in ID.
- ifid_uses_rs1, ifid_uses_rs2  input  1  ID instruction actually reads rs1/rs2.
- idex_rs1, idex_rs2, idex_rd  input  REG_ADDR_W  register indices of the instruction in EX.
- idex_mem_read  input  1  EX instruction is a load.
- idex_reg_write  input  1  EX instruction writes rd.
- idex_mdu_start  input  1  EX instruction is an MDU operation.
- exmem_rd  input  REG_ADDR_W  EX/MEM destination register.
- exmem_reg_write  input  1  EX/MEM register write enable.
- memwb_rd  input  REG_ADDR_W  MEM/WB destination register.
- memwb_reg_write  input  1  MEM/WB register write enable.
- branch_taken  input  1  EX resolved a taken branch or jump.
- forward_a, forward_b  output  2  operand select: 00 register file, 10 EX/MEM, 01 MEM/WB.
- pc_write, ifid_write, idex_write  output  1  pipeline register enables.
- idex_bubble  output  1  load a NOP into ID/EX.
- exmem_bubble  output  1  load a NOP into EX/MEM.
- ifid_flush  output  1  clear IF/ID.
- mdu_busy  output  1  MDU stall active.
- stall_count, flush_count  output  CNT_W  saturating event counters.

## Operation

Forwarding (combinational, evaluated every cycle):
- forward_a = 10 when exmem_reg_write, exmem_rd≠0 and exmem_rd==idex_rs1.
- Otherwise forward_a = 01 when memwb_reg_write, memwb_rd≠0 and memwb_rd==idex_rs1.
- Otherwise forward_a = 00.
- forward_b follows the same rules using idex_rs2.
- EX/MEM always wins over MEM/WB.

Load-use hazard:
- loaduse = idex_mem_read & idex_reg_write & idex_rd≠0 & ((ifid_uses_rs1 & idex_rd==ifid_rs1) | (ifid_uses_rs2 & idex_rd==ifid_rs2)).

FSM states are IDLE, MDU_BUSY and MDU_LAST. A down-counter cnt is CLOG2(MDU_LATENCY) wide.

IDLE, priority order:
1. branch_taken: ifid_flush=1, idex_bubble=1, pc_write=1. MDU start and load-use are ignored.
2. idex_mdu_start with MDU_LATENCY≥2:
   - stall asserted this cycle.
   - If MDU_LATENCY==2, next state is MDU_LAST.
   - Otherwise cnt←MDU_LATENCY−2 and next state is MDU_BUSY.
3. loaduse: pc_write=0, ifid_write=0, idex_bubble=1. Stays in IDLE.

MDU_BUSY:
- Stall asserted.
- If cnt==1, go to MDU_LAST; else cnt←cnt−1.
- branch_taken, loaduse and idex_mdu_start are ignored.

MDU_LAST (release cycle):
- No stall.
- idex_mdu_start is ignored, because the same instruction is still in ID/EX.
- loaduse and branch_taken are evaluated as in IDLE.
- Next state is IDLE.

Stall (MDU):
- pc_write=0, ifid_write=0, idex_write=0, exmem_bubble=1, mdu_busy=1.
- The MDU latches its operands in the start cycle.

Default output values: pc_write=ifid_write=idex_write=1; all bubble, flush and busy outputs 0.

Counters:
- stall_count +1 on every cycle with a load-use or MDU stall.
- flush_count +1 on every cycle branch_taken is accepted.
- Both saturate at all-ones; there is no wrap.

## Timing

- Reset values:
  - state=IDLE, cnt=0, stall_count=0, flush_count=0.
  - While reset is high: default enables, all bubble/flush/busy outputs 0, forward_a=forward_b=00.
- Forwarding, load-use and flush outputs are combinational, with zero latency.
- MDU instruction first seen in ID/EX at cycle T:
  - stall is asserted during T … T+MDU_LATENCY−2;
  - release cycle is T+MDU_LATENCY−1;
  - the instruction advances to EX/MEM at the end of the release cycle.
- MDU_LATENCY=1: no MDU stall ever; the FSM stays in IDLE.
- Reset asserted mid-MDU: the FSM is IDLE on the next cycle with stall deasserted. The pipeline flush is the caller's responsibility.
- branch_taken together with loaduse: the flush wins. No stall is counted; flush_count +1.
- Counter at all-ones plus a new event: the value holds.

## Test plan

- Forwarding priority:
  - exmem_rd=memwb_rd=idex_rs1=5, both write enables set → forward_a=10.
  - Clearing exmem_reg_write → 01.
  - Setting all rd fields to 0 → 00.
- Load-use:
  - idex_mem_read=1, idex_reg_write=1, idex_rd=7, ifid_rs2=7, ifid_uses_rs2=1 → for exactly one cycle pc_write=0, ifid_write=0, idex_bubble=1; stall_count 0→1.
  - With ifid_uses_rs2=0 → no stall.
- MDU with MDU_LATENCY=4:
  - idex_mdu_start held high from cycle T → mdu_busy=1 and idex_write=0 on T, T+1, T+2.
  - T+3 is the release cycle: mdu_busy=0, idex_write=1 with start still high.
  - stall_count=3.
- Branch:
  - branch_taken in IDLE with loaduse true → ifid_flush=1, idex_bubble=1, pc_write=1, flush_count=1, stall_count unchanged.
- Reset mid-MDU:
  - MDU_LATENCY=4, start at T, reset high during T+1 → at T+2 state IDLE, mdu_busy=0, both counters 0.
- Saturation:
  - CNT_W=4, 20 consecutive load-use cycles → stall_count=15.

Source files
------------

// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit
//
// Hazard controller for the five-stage pipeline, sitting beside the ID/EX boundary.
//   - EX operand forwarding (EX/MEM beats MEM/WB, x0 never forwarded)
//   - load-use stall detection
//   - multi-cycle MDU stall sequencer (IDLE -> MDU_BUSY -> MDU_LAST)
//   - branch flush control
//   - saturating stall / flush event counters
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   ifid_*                      source registers of the instruction in ID
//   idex_*                      register indices and control of the instruction in EX
//   exmem_*, memwb_*            destination register and write enable of later stages
//   branch_taken                EX resolved a taken branch or jump
//   forward_a, forward_b        operand select: 00 regfile, 10 EX/MEM, 01 MEM/WB
//   pc_write, ifid_write,
//   idex_write                  pipeline register enables
//   idex_bubble, exmem_bubble   NOP insertion into ID/EX, EX/MEM
//   ifid_flush                  clear IF/ID
//   mdu_busy                    MDU stall active
//   stall_count, flush_count    saturating event counters
module hazard_forward_unit #(
    parameter int unsigned REG_ADDR_W  = 5,
    parameter int unsigned MDU_LATENCY = 4,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] ifid_rs1,
    input  logic [REG_ADDR_W-1:0] ifid_rs2,
    input  logic                  ifid_uses_rs1,
    input  logic                  ifid_uses_rs2,
    input  logic [REG_ADDR_W-1:0] idex_rs1,
    input  logic [REG_ADDR_W-1:0] idex_rs2,
    input  logic [REG_ADDR_W-1:0] idex_rd,
    input  logic                  idex_mem_read,
    input  logic                  idex_reg_write,
    input  logic                  idex_mdu_start,
    input  logic [REG_ADDR_W-1:0] exmem_rd,
    input  logic                  exmem_reg_write,
    input  logic [REG_ADDR_W-1:0] memwb_rd,
    input  logic                  memwb_reg_write,
    input  logic                  branch_taken,
    output logic [1:0]            forward_a,
    output logic [1:0]            forward_b,
    output logic                  pc_write,
    output logic                  ifid_write,
    output logic                  idex_write,
    output logic                  idex_bubble,
    output logic                  exmem_bubble,
    output logic                  ifid_flush,
    output logic                  mdu_busy,
    output logic [CNT_W-1:0]      stall_count,
    output logic [CNT_W-1:0]      flush_count
);

    // Counter must hold MDU_LATENCY-2; keep at least one bit when MDU stalling is disabled.
    localparam int unsigned CntW   = (MDU_LATENCY > 1) ? $clog2(MDU_LATENCY) : 1;
    localparam int unsigned LoadV  = (MDU_LATENCY >= 2) ? (MDU_LATENCY - 2) : 0;
    localparam logic [CntW-1:0] CntLoad = CntW'(LoadV);
    localparam bit MduEn = (MDU_LATENCY >= 2);
    localparam bit MduShort = (MDU_LATENCY == 2);

    typedef enum logic [1:0] {StIdle, StMduBusy, StMduLast} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;
    logic [CNT_W-1:0] flush_count_q, flush_count_d;

    logic loaduse;
    logic mdu_stall;
    logic lu_stall;
    logic flush_acc;

    function automatic logic [1:0] fwd_sel(
        input logic [REG_ADDR_W-1:0] rs,
        input logic [REG_ADDR_W-1:0] ex_rd,
        input logic                  ex_we,
        input logic [REG_ADDR_W-1:0] wb_rd,
        input logic                  wb_we
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (ex_we && (ex_rd != '0) && (ex_rd == rs)) begin
            sel = 2'b10;
        end else if (wb_we && (wb_rd != '0) && (wb_rd == rs)) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    always_comb begin
        loaduse = idex_mem_read && idex_reg_write && (idex_rd != '0) &&
                  ((ifid_uses_rs1 && (idex_rd == ifid_rs1)) ||
                   (ifid_uses_rs2 && (idex_rd == ifid_rs2)));
    end

    // Next-state and event decode.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mdu_stall = 1'b0;
        lu_stall  = 1'b0;
        flush_acc = 1'b0;
        if (!reset) begin
            case (state_q)
                StIdle, StMduLast: begin
                    if (state_q == StMduLast) begin
                        state_d = StIdle;
                    end
                    if (branch_taken) begin
                        flush_acc = 1'b1;
                    end else if (MduEn && idex_mdu_start && (state_q == StIdle)) begin
                        // The release cycle ignores start: the same op is still in ID/EX.
                        mdu_stall = 1'b1;
                        if (MduShort) begin
                            state_d = StMduLast;
                        end else begin
                            cnt_d   = CntLoad;
                            state_d = StMduBusy;
                        end
                    end else if (loaduse) begin
                        lu_stall = 1'b1;
                    end
                end
                StMduBusy: begin
                    mdu_stall = 1'b1;
                    if (cnt_q == CntW'(1)) begin
                        state_d = StMduLast;
                    end else begin
                        cnt_d = cnt_q - CntW'(1);
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        stall_count_d = stall_count_q;
        if ((mdu_stall || lu_stall) && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + CNT_W'(1);
        end
        flush_count_d = flush_count_q;
        if (flush_acc && (flush_count_q != '1)) begin
            flush_count_d = flush_count_q + CNT_W'(1);
        end
    end

    // Outputs: all zero-latency from current state and inputs.
    always_comb begin
        forward_a    = 2'b00;
        forward_b    = 2'b00;
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        idex_write   = 1'b1;
        idex_bubble  = 1'b0;
        exmem_bubble = 1'b0;
        ifid_flush   = 1'b0;
        mdu_busy     = 1'b0;
        if (!reset) begin
            forward_a = fwd_sel(idex_rs1, exmem_rd, exmem_reg_write, memwb_rd, memwb_reg_write);
            forward_b = fwd_sel(idex_rs2, exmem_rd, exmem_reg_write, memwb_rd, memwb_reg_write);
        end
        if (mdu_stall) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_write   = 1'b0;
            exmem_bubble = 1'b1;
            mdu_busy     = 1'b1;
        end
        if (lu_stall) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end
        if (flush_acc) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end
    end

    assign stall_count = stall_count_q;
    assign flush_count = flush_count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Self-checking bench for hazard_forward_unit (MDU_LATENCY=4, CNT_W=4).
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_hazard_forward_unit;

    localparam int unsigned AW  = 5;
    localparam int unsigned LAT = 4;
    localparam int unsigned CW  = 4;
    localparam int unsigned OW  = 11 + 2 * CW;
    localparam int          CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [AW-1:0] ifid_rs1, ifid_rs2;
    logic          ifid_uses_rs1, ifid_uses_rs2;
    logic [AW-1:0] idex_rs1, idex_rs2, idex_rd;
    logic          idex_mem_read, idex_reg_write, idex_mdu_start;
    logic [AW-1:0] exmem_rd;
    logic          exmem_reg_write;
    logic [AW-1:0] memwb_rd;
    logic          memwb_reg_write;
    logic          branch_taken;
    logic [1:0]    forward_a, forward_b;
    logic          pc_write, ifid_write, idex_write;
    logic          idex_bubble, exmem_bubble, ifid_flush, mdu_busy;
    logic [CW-1:0] stall_count, flush_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: remaining MDU stall cycles, pending release, event totals.
    int m_busy, n_busy;
    bit m_rel, n_rel;
    int m_stall, m_flush, n_stall, n_flush;
    logic [OW-1:0] exp_v;
    logic [OW-1:0] obs_v;

    always #5 clk = ~clk;

    hazard_forward_unit #(
        .REG_ADDR_W (AW),
        .MDU_LATENCY(LAT),
        .CNT_W      (CW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .ifid_rs1       (ifid_rs1),
        .ifid_rs2       (ifid_rs2),
        .ifid_uses_rs1  (ifid_uses_rs1),
        .ifid_uses_rs2  (ifid_uses_rs2),
        .idex_rs1       (idex_rs1),
        .idex_rs2       (idex_rs2),
        .idex_rd        (idex_rd),
        .idex_mem_read  (idex_mem_read),
        .idex_reg_write (idex_reg_write),
        .idex_mdu_start (idex_mdu_start),
        .exmem_rd       (exmem_rd),
        .exmem_reg_write(exmem_reg_write),
        .memwb_rd       (memwb_rd),
        .memwb_reg_write(memwb_reg_write),
        .branch_taken   (branch_taken),
        .forward_a      (forward_a),
        .forward_b      (forward_b),
        .pc_write       (pc_write),
        .ifid_write     (ifid_write),
        .idex_write     (idex_write),
        .idex_bubble    (idex_bubble),
        .exmem_bubble   (exmem_bubble),
        .ifid_flush     (ifid_flush),
        .mdu_busy       (mdu_busy),
        .stall_count    (stall_count),
        .flush_count    (flush_count)
    );

    assign obs_v = {forward_a, forward_b, pc_write, ifid_write, idex_write, idex_bubble,
                    exmem_bubble, ifid_flush, mdu_busy, stall_count, flush_count};

    task automatic clear_inputs();
        ifid_rs1 = '0; ifid_rs2 = '0; ifid_uses_rs1 = 0; ifid_uses_rs2 = 0;
        idex_rs1 = '0; idex_rs2 = '0; idex_rd = '0;
        idex_mem_read = 0; idex_reg_write = 0; idex_mdu_start = 0;
        exmem_rd = '0; exmem_reg_write = 0; memwb_rd = '0; memwb_reg_write = 0;
        branch_taken = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1;
        clear_inputs();
        @(negedge clk);
        reset = 0;
        m_busy = 0; m_rel = 0; m_stall = 0; m_flush = 0;
    endtask

    task automatic set_loaduse();
        idex_mem_read = 1; idex_reg_write = 1; idex_rd = 5'd7;
        ifid_rs2 = 5'd7; ifid_uses_rs2 = 1;
    endtask

    function automatic logic [1:0] ref_fwd(input logic [AW-1:0] rs);
        if (exmem_reg_write && exmem_rd != 0 && exmem_rd == rs) return 2'b10;
        if (memwb_reg_write && memwb_rd != 0 && memwb_rd == rs) return 2'b01;
        return 2'b00;
    endfunction

    // Expected outputs for the current inputs plus the model's next state.
    task automatic model_eval();
        logic [1:0] fa, fb;
        logic pcw, ifw, idw, ib, eb, fl, bz;
        bit stall, lus, flush, lu;
        fa = 0; fb = 0; pcw = 1; ifw = 1; idw = 1; ib = 0; eb = 0; fl = 0; bz = 0;
        stall = 0; lus = 0; flush = 0;
        n_busy = m_busy; n_rel = 0;
        lu = idex_mem_read && idex_reg_write && idex_rd != 0 &&
             ((ifid_uses_rs1 && idex_rd == ifid_rs1) || (ifid_uses_rs2 && idex_rd == ifid_rs2));
        if (reset) begin
            n_busy = 0;
        end else begin
            fa = ref_fwd(idex_rs1);
            fb = ref_fwd(idex_rs2);
            if (m_busy > 0) begin
                stall = 1;
                n_busy = m_busy - 1;
                n_rel = (n_busy == 0);
            end else if (branch_taken) begin
                flush = 1;
            end else if (!m_rel && idex_mdu_start && LAT >= 2) begin
                stall = 1;
                n_busy = LAT - 2;
                n_rel = (n_busy == 0);
            end else if (lu) begin
                lus = 1;
            end
        end
        if (stall) begin pcw = 0; ifw = 0; idw = 0; eb = 1; bz = 1; end
        if (lus) begin pcw = 0; ifw = 0; ib = 1; end
        if (flush) begin fl = 1; ib = 1; end
        exp_v = {fa, fb, pcw, ifw, idw, ib, eb, fl, bz, CW'(m_stall), CW'(m_flush)};
        if (reset) begin
            n_stall = 0; n_flush = 0;
        end else begin
            n_stall = (stall || lus) ? ((m_stall < CMAX) ? m_stall + 1 : CMAX) : m_stall;
            n_flush = flush ? ((m_flush < CMAX) ? m_flush + 1 : CMAX) : m_flush;
        end
    endtask

    task automatic model_commit();
        m_busy = n_busy; m_rel = n_rel; m_stall = n_stall; m_flush = n_flush;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1;
        branch_taken = 1; idex_mdu_start = 1; set_loaduse();
        exmem_reg_write = 1; exmem_rd = 5'd3; idex_rs1 = 5'd3; idex_rs2 = 5'd3;
        #1;
        n_checks++;
        if (obs_v[OW-1:2*CW] !== 11'b00_00_111_0000) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected %b", obs_v[OW-1:2*CW], 11'b00_00_111_0000);
        end
        @(negedge clk);
        reset = 0;
        clear_inputs();
        #1;
        n_checks++;
        if (obs_v !== {11'b00_00_111_0000, {2*CW{1'b0}}}) begin
            n_fail++;
            $display("FAIL reset_state: got %h expected %h", obs_v, {11'b00_00_111_0000, {2*CW{1'b0}}});
        end
        m_busy = 0; m_rel = 0; m_stall = 0; m_flush = 0;
    endtask

    task automatic test_forwarding();
        @(negedge clk);
        exmem_rd = 5'd5; memwb_rd = 5'd5; idex_rs1 = 5'd5; idex_rs2 = 5'd6;
        exmem_reg_write = 1; memwb_reg_write = 1;
        #1;
        n_checks++;
        if ({forward_a, forward_b} !== 4'b10_00) begin
            n_fail++;
            $display("FAIL fwd_exmem_priority: got %b expected %b", {forward_a, forward_b}, 4'b1000);
        end
        @(negedge clk);
        exmem_reg_write = 0; idex_rs2 = 5'd5;
        #1;
        n_checks++;
        if ({forward_a, forward_b} !== 4'b01_01) begin
            n_fail++;
            $display("FAIL fwd_memwb: got %b expected %b", {forward_a, forward_b}, 4'b0101);
        end
        @(negedge clk);
        exmem_reg_write = 1; exmem_rd = 5'd6; idex_rs2 = 5'd6;
        #1;
        n_checks++;
        if ({forward_a, forward_b} !== 4'b01_10) begin
            n_fail++;
            $display("FAIL fwd_split: got %b expected %b", {forward_a, forward_b}, 4'b0110);
        end
        @(negedge clk);
        exmem_rd = 0; memwb_rd = 0; idex_rs1 = 0; idex_rs2 = 0;
        #1;
        n_checks++;
        if ({forward_a, forward_b} !== 4'b00_00) begin
            n_fail++;
            $display("FAIL fwd_x0: got %b expected %b", {forward_a, forward_b}, 4'b0000);
        end
        clear_inputs();
    endtask

    task automatic test_load_use();
        do_reset();
        @(negedge clk);
        set_loaduse();
        #1;
        n_checks++;
        if ({pc_write, ifid_write, idex_bubble, idex_write, stall_count} !== {4'b0011, CW'(0)}) begin
            n_fail++;
            $display("FAIL loaduse_stall: got %b expected %b",
                     {pc_write, ifid_write, idex_bubble, idex_write, stall_count}, {4'b0011, CW'(0)});
        end
        @(negedge clk);
        idex_mem_read = 0; idex_reg_write = 0; idex_rd = 0;
        #1;
        n_checks++;
        if ({pc_write, ifid_write, idex_bubble, stall_count} !== {3'b110, CW'(1)}) begin
            n_fail++;
            $display("FAIL loaduse_one_cycle: got %b expected %b",
                     {pc_write, ifid_write, idex_bubble, stall_count}, {3'b110, CW'(1)});
        end
        @(negedge clk);
        set_loaduse();
        ifid_uses_rs2 = 0;
        #1;
        n_checks++;
        if ({pc_write, ifid_write, idex_bubble} !== 3'b110) begin
            n_fail++;
            $display("FAIL loaduse_unused_rs2: got %b expected %b",
                     {pc_write, ifid_write, idex_bubble}, 3'b110);
        end
        @(negedge clk);
        idex_rd = 0; ifid_rs1 = 0; ifid_uses_rs1 = 1; ifid_rs2 = 0; ifid_uses_rs2 = 1;
        #1;
        n_checks++;
        if ({pc_write, idex_bubble, stall_count} !== {2'b10, CW'(1)}) begin
            n_fail++;
            $display("FAIL loaduse_x0: got %b expected %b", {pc_write, idex_bubble, stall_count},
                     {2'b10, CW'(1)});
        end
        clear_inputs();
    endtask

    task automatic test_mdu();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            idex_mdu_start = 1;
            #1;
            n_checks++;
            if ({mdu_busy, idex_write, pc_write, exmem_bubble} !== ((i < 3) ? 4'b1001 : 4'b0110)) begin
                n_fail++;
                $display("FAIL mdu_cycle%0d: got %b expected %b", i,
                         {mdu_busy, idex_write, pc_write, exmem_bubble},
                         ((i < 3) ? 4'b1001 : 4'b0110));
            end
        end
        @(negedge clk);
        idex_mdu_start = 0;
        #1;
        n_checks++;
        if ({mdu_busy, stall_count} !== {1'b0, CW'(3)}) begin
            n_fail++;
            $display("FAIL mdu_stall_count: got %h expected %h", {mdu_busy, stall_count},
                     {1'b0, CW'(3)});
        end
    endtask

    task automatic test_branch();
        do_reset();
        @(negedge clk);
        set_loaduse();
        branch_taken = 1;
        #1;
        n_checks++;
        if ({ifid_flush, idex_bubble, pc_write, ifid_write} !== 4'b1111) begin
            n_fail++;
            $display("FAIL branch_flush: got %b expected %b",
                     {ifid_flush, idex_bubble, pc_write, ifid_write}, 4'b1111);
        end
        @(negedge clk);
        clear_inputs();
        #1;
        n_checks++;
        if ({flush_count, stall_count} !== {CW'(1), CW'(0)}) begin
            n_fail++;
            $display("FAIL branch_counts: got %h expected %h", {flush_count, stall_count},
                     {CW'(1), CW'(0)});
        end
    endtask

    task automatic test_reset_mid_mdu();
        do_reset();
        @(negedge clk);
        idex_mdu_start = 1;
        #1;
        n_checks++;
        if (mdu_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midmdu_start: got %b expected 1", mdu_busy);
        end
        @(negedge clk);
        reset = 1;
        #1;
        n_checks++;
        if ({mdu_busy, idex_write} !== 2'b01) begin
            n_fail++;
            $display("FAIL midmdu_in_reset: got %b expected 01", {mdu_busy, idex_write});
        end
        @(negedge clk);
        reset = 0;
        idex_mdu_start = 0;
        #1;
        n_checks++;
        if ({mdu_busy, idex_write, stall_count, flush_count} !== {2'b01, CW'(0), CW'(0)}) begin
            n_fail++;
            $display("FAIL midmdu_after_reset: got %h expected %h",
                     {mdu_busy, idex_write, stall_count, flush_count}, {2'b01, CW'(0), CW'(0)});
        end
        // A fresh op must see the full three-cycle stall, proving the sequencer restarted.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            idex_mdu_start = 1;
            #1;
            n_checks++;
            if (mdu_busy !== (i < 3)) begin
                n_fail++;
                $display("FAIL midmdu_restart%0d: got %b expected %b", i, mdu_busy, (i < 3));
            end
        end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            set_loaduse();
            #1;
            if (i == 15) begin
                n_checks++;
                if (stall_count !== CW'(15)) begin
                    n_fail++;
                    $display("FAIL sat_reach: got %0d expected 15", stall_count);
                end
            end
        end
        @(negedge clk);
        clear_inputs();
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            branch_taken = 1;
        end
        @(negedge clk);
        branch_taken = 0;
        #1;
        n_checks++;
        if ({stall_count, flush_count} !== {CW'(15), CW'(15)}) begin
            n_fail++;
            $display("FAIL sat_hold: got %h expected %h", {stall_count, flush_count},
                     {CW'(15), CW'(15)});
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            reset           = ($urandom_range(0, 49) == 0);
            ifid_rs1        = AW'($urandom_range(0, 3));
            ifid_rs2        = AW'($urandom_range(0, 3));
            ifid_uses_rs1   = 1'($urandom);
            ifid_uses_rs2   = 1'($urandom);
            idex_rs1        = AW'($urandom_range(0, 3));
            idex_rs2        = AW'($urandom_range(0, 3));
            idex_rd         = AW'($urandom_range(0, 3));
            idex_mem_read   = 1'($urandom);
            idex_reg_write  = 1'($urandom);
            idex_mdu_start  = ($urandom_range(0, 5) == 0);
            exmem_rd        = AW'($urandom_range(0, 3));
            exmem_reg_write = 1'($urandom);
            memwb_rd        = AW'($urandom_range(0, 3));
            memwb_reg_write = 1'($urandom);
            branch_taken    = ($urandom_range(0, 5) == 0);
            #1;
            model_eval();
            n_checks++;
            if (obs_v !== exp_v) begin
                n_fail++;
                $display("FAIL random_cycle%0d: got %b expected %b", i, obs_v, exp_v);
            end
            model_commit();
        end
        @(negedge clk);
        reset = 0;
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_forwarding();
        test_load_use();
        test_mdu();
        test_branch();
        test_reset_mid_mdu();
        test_saturation();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
